// File: rtl/idct_1d_seq.sv
// Sequential 8-point 1-D IDCT: one coefficient row per cycle, eight parallel accumulators.
// Optional macro IDCT_1D_SAT_EN: saturate samples to [0,255] instead of wrapping to 8 bits.
module idct_1d_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [63:0]        z_reg;
    logic [2:0]         k;
    logic signed [21:0] acc      [8];
    logic signed [21:0] acc_next [8];
    logic signed [7:0]  z_k;
    logic signed [19:0] prod     [8];
    logic [63:0]        result;

    // Basis coefficient C[k][n]; cos((2n+1)k*pi/16) folded into the first quadrant.
    function automatic logic signed [11:0] coef(input logic [2:0] kk, input logic [2:0] nn);
        logic [6:0]         p;
        logic [4:0]         m;
        logic [4:0]         r;
        logic               neg;
        logic signed [11:0] c;
        if (kk == 3'd0)
            return 12'sd724;
        p   = {3'b000, nn, 1'b1} * {4'b0000, kk};
        m   = p[4:0];
        r   = (m > 5'd16) ? 5'(6'd32 - {1'b0, m}) : m;
        neg = (r > 5'd8);
        if (neg)
            r = 5'd16 - r;
        case (r)
            5'd0:    c = 12'sd1024;
            5'd1:    c = 12'sd1004;
            5'd2:    c = 12'sd946;
            5'd3:    c = 12'sd851;
            5'd4:    c = 12'sd724;
            5'd5:    c = 12'sd569;
            5'd6:    c = 12'sd392;
            5'd7:    c = 12'sd200;
            default: c = 12'sd0;
        endcase
        return neg ? -c : c;
    endfunction

    // Round, floor-shift by 8, then map to an unsigned byte.
    function automatic logic [7:0] map_sample(input logic signed [21:0] a);
        logic signed [21:0] r;
        r = a + 22'sd128;
`ifdef IDCT_1D_SAT_EN
        if (r[21])
            return '0;
        if (r[20:16] != 5'd0)
            return '1;
        return r[15:8];
`else
        return r[15:8];
`endif
    endfunction

    always_comb begin
        z_k    = z_reg[{~k, 3'b111} -: 8];
        result = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            prod[n]     = 20'(z_k) * 20'(coef(k, 3'(n)));
            acc_next[n] = acc[n] + {{2{prod[n][19]}}, prod[n]};
            result[{~3'(n), 3'b000} +: 8] = map_sample(acc_next[n]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= '0;
            z_reg     <= '0;
            k         <= '0;
            for (int unsigned n = 0; n < 8; n++)
                acc[n] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_reg    <= data_in;
                        k        <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                        for (int unsigned n = 0; n < 8; n++)
                            acc[n] <= '0;
                    end
                end
                CALC: begin
                    for (int unsigned n = 0; n < 8; n++)
                        acc[n] <= acc_next[n];
                    k <= k + 3'd1;
                    // Last term is folded in combinationally so the result lands with DONE.
                    if (k == 3'd7) begin
                        data_out  <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_1d_seq.sv
// Directed bench for idct_1d_seq; expectations depend on IDCT_1D_SAT_EN.
module tb_idct_1d_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;

    int n_checks;
    int n_fail;

`ifdef IDCT_1D_SAT_EN
    localparam logic [63:0] EXP_POS_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_NEG_MAX = 64'h0000_0000_0000_0000;
`else
    localparam logic [63:0] EXP_POS_MAX = 64'h6767_6767_6767_6767;
    localparam logic [63:0] EXP_NEG_MAX = 64'h9696_9696_9696_9696;
`endif

    idct_1d_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: present a block, scramble data_in afterwards, count negedges until out_valid.
    task automatic send_block(input logic [63:0] d, output int cyc, output logic [63:0] res);
        @(negedge clk);
        in_valid  = 1'b1;
        data_in   = d;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = 64'hA5A5_5A5A_FFFF_0180;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        res = data_out;
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b data_out=%h, want 1 0 0", in_ready, out_valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vector(input string name, input logic [63:0] d, input logic [63:0] exp);
        int cyc;
        logic [63:0] res;
        send_block(d, cyc, res);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, want 8", name, cyc);
        end
        n_checks++;
        if (res !== exp) begin
            n_fail++;
            $display("FAIL %s_data: got %h, want %h", name, res, exp);
        end
        release_output();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b, want 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [63:0] res;
        send_block(64'h2D00_0000_0000_0000, cyc, res);
        n_checks++;
        if (res !== 64'h7F7F_7F7F_7F7F_7F7F) begin
            n_fail++;
            $display("FAIL bp_first_data: got %h, want 7f7f7f7f7f7f7f7f", res);
        end
        in_valid = 1'b1;
        data_in  = 64'h7F00_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_out !== 64'h7F7F_7F7F_7F7F_7F7F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: data_out=%h out_valid=%b in_ready=%b", i, data_out, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshake: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
        end
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc !== 8 || data_out !== EXP_POS_MAX) begin
            n_fail++;
            $display("FAIL bp_second: cycles=%0d data_out=%h, want 8 %h", cyc, data_out, EXP_POS_MAX);
        end
        release_output();
    endtask

    task automatic test_reset_mid_calc();
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 64'h2D10_0000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reset_async: in_ready=%b out_valid=%b data_out=%h, want 1 0 0", in_ready, out_valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_output: out_valid high %0d cycles, want 0", seen);
        end
        test_vector("after_reset", 64'h2D00_0000_0000_0000, 64'h7F7F_7F7F_7F7F_7F7F);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_vector("zero",    64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        test_vector("dc45",    64'h2D00_0000_0000_0000, 64'h7F7F_7F7F_7F7F_7F7F);
        test_vector("dc45_ac", 64'h2D10_0000_0000_0000, 64'hBEB4_A38C_735C_4A41);
        test_vector("pos_max", 64'h7F00_0000_0000_0000, EXP_POS_MAX);
        test_vector("neg_max", 64'h8000_0000_0000_0000, EXP_NEG_MAX);
        test_backpressure();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/idct_1d_seq.md
IDCT_1D_SEQ -- requirements
Module: idct_1d_seq

Interface
REQ-001 Parameters: none; all widths fixed as stated below.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  coefficient block present on data_in.
REQ-005 in_ready  output  1  block accepts a new coefficient block.
REQ-006 data_in  input  64  8 signed two's-complement 8-bit coefficients; z0 in [63:56] through z7 in [7:0].
REQ-007 out_valid  output  1  data_out holds a completed sample vector.
REQ-008 out_ready  input  1  downstream accepts data_out.
REQ-009 data_out  output  64  8 unsigned 8-bit samples; x0 in [63:56] through x7 in [7:0].

Function
REQ-010 The block SHALL compute the inverse of the team's 1-D DCT, whose coefficients are the orthonormal DCT divided by 8.
- x_n = sum over k of z_k*C[k][n], then rounded and shifted per REQ-016.
- C[k][n] = round(256*B_k*cos((2n+1)k*pi/16)), rounding half away from zero.
- B_0 = 2*sqrt(2); B_k = 4 for k = 1..7.
- Sample values: C[0][n] = 724; C[1][0..7] = 1004, 851, 569, 200, -200, -569, -851, -1004.
REQ-011 The block SHALL have FSM states IDLE, CALC and DONE.
REQ-012 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-013 When in_valid and in_ready are both 1 at a rising edge, the block SHALL:
- register data_in;
- clear all 8 accumulators;
- set k counter to 0;
- enter CALC.
REQ-014 Each CALC cycle SHALL:
- add z_k*C[k][n] into accumulator n, for all n in parallel;
- increment k.
After the k=7 cycle, the block SHALL enter DONE (exactly 8 CALC cycles).
REQ-015 Accumulators SHALL be 22-bit signed.
- Products: 8-bit signed times 12-bit signed constant.
- No intermediate overflow is possible.
REQ-016 On the CALC->DONE transition, each result SHALL be (acc + 128) arithmetically shifted right by 8 (floor), then mapped to 8 bits per REQ-025.
REQ-017 Latency: out_valid SHALL rise 8 cycles after the accepting edge.
REQ-018 In DONE, out_valid SHALL be 1 and data_out SHALL remain stable until out_valid and out_ready are both 1 at an edge; then the block SHALL return to IDLE.
REQ-019 Accept/issue rules:
- The next block SHALL be accepted no earlier than the edge after the output handshake.
- Minimum period: 10 cycles per block.
REQ-020 in_valid SHALL be ignored outside IDLE; data_in changes during CALC/DONE SHALL NOT affect the result.
REQ-021 Outside DONE, out_valid SHALL be 0 and data_out SHALL hold its last value (0 after reset).

Reset
REQ-022 rst_n low SHALL immediately, without waiting for a clock edge:
- force state IDLE;
- set in_ready=1, out_valid=0, data_out=0;
- clear accumulators, k and the input register.
REQ-023 Reset during CALC or DONE SHALL discard the in-flight block; no out_valid pulse SHALL follow.
REQ-024 After rst_n rises, the first rising edge SHALL be able to accept a block.

Configuration
REQ-025 Macro IDCT_1D_SAT_EN:
- Defined: each shifted result SHALL saturate to [0,255] (negative -> 0, above 255 -> 255).
- Undefined: each result SHALL be truncated to its low 8 bits (wrap-around).

Verification
REQ-026 The bench SHALL cover at least these scenarios:
- Reset, then data_in all zero, accepted -> after 8 cycles data_out = 0x0000000000000000, out_valid=1.
- z0=45, others 0 -> all eight samples = 127.
- z0=45, z1=16, others 0 -> x0..x7 = 190, 180, 163, 140, 115, 92, 74, 65.
- z0=127, others 0 -> all samples 255 with IDCT_1D_SAT_EN, 103 without; z0=-128, others 0 -> 0 with the macro.
- out_ready held 0 for 5 cycles in DONE while in_valid=1 with new data -> data_out stable, in_ready=0, new block not captured; block accepted only after the handshake plus 1 edge.
- rst_n pulsed low during the 4th CALC cycle -> out_valid stays 0, in_ready=1 immediately; next block z0=45 gives all samples = 127.
